inst_fetch_unit: RTL and testbench

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

---
 rtl/inst_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_inst_fetch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: combinational-memory fetch into a small in-order queue with redirect flush.
// Optional halt on ECALL is enabled by defining FETCH_HALT_ON_ECALL_EN.

module inst_fetch_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop,
   output logic [W-1:0]             head_dat,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          empty;
   logic          pop_en;
   logic          push_en;

   assign empty   = (count == '0);
   assign full    = (count == CNT_DEPTH);
   assign pop_en  = pop && !empty;
   // A push into a full queue is legal only when the head leaves in the same cycle.
   assign push_en = push && (!full || pop_en);

   assign head_dat = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_en)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push_en && !pop_en)      count <= count + CNT_ONE;
         else if (pop_en && !push_en) count <= count - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en && !flush) mem[wr_ptr] <= push_dat;
   end
endmodule

module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_dout,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        halted
);
   localparam int          CW    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [31:0] ECALL = 32'h0000_0073;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } fetch_ent_t;

   typedef enum logic {RUN, HALT} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [29:0] fetch_word;
   logic        push;
   logic        pop;
   logic        full;
   logic [CW-1:0] count;
   fetch_ent_t  push_ent;
   fetch_ent_t  head_ent;
   logic        unused_bits;

   // The PC is kept as a word index so the low address bits are zero by construction.
   assign imem_addr   = {fetch_word, 2'b00};
   assign unused_bits = ^redirect_pc[1:0];

   assign inst_valid = (count != '0);
   assign pop        = inst_valid && inst_ready;
   assign push       = (state == RUN) && !redirect_valid && (!full || pop);

   assign push_ent.pc   = imem_addr;
   assign push_ent.word = imem_dout;
   assign inst          = head_ent.word;
   assign inst_pc       = head_ent.pc;

   inst_fetch_fifo #(
      .W     ($bits(fetch_ent_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_queue (
      .clk      (clk),
      .reset    (reset),
      .flush    (redirect_valid),
      .push     (push),
      .push_dat (push_ent),
      .pop      (pop),
      .head_dat (head_ent),
      .count    (count),
      .full     (full)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_word <= RESET_PC[31:2];
      end else if (redirect_valid) begin
         fetch_word <= redirect_pc[31:2];
      end else if (push) begin
         fetch_word <= fetch_word + 30'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (redirect_valid) begin
         state_nxt = RUN;
`ifdef FETCH_HALT_ON_ECALL_EN
      end else if (push && (imem_dout == ECALL)) begin
         state_nxt = HALT;
`endif
      end
   end

`ifdef FETCH_HALT_ON_ECALL_EN
   assign halted = (state == HALT);
`else
   assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus random traffic against a queue model.
module tb_inst_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_dout;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halted;

   logic        ecall_en   = 1'b0;
   logic [31:0] ecall_addr = 32'h8;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] w;
   } ent_t;

   ent_t        m_q[$];
   logic [31:0] m_pc;
   logic        m_halt;

   always #5 clk = ~clk;

   inst_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_dout(imem_dout),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
   );

   function automatic logic [31:0] memword(input logic [31:0] a, input logic en, input logic [31:0] ea);
      if (en && a == ea) return 32'h0000_0073;
      return 32'h1000_0000 + (a >> 2);
   endfunction

   always_comb imem_dout = memword(imem_addr, ecall_en, ecall_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc   = RESET_PC;
      m_halt = 1'b0;
   endtask

   // One clock edge of the behavioural model, evaluated with the inputs seen at that edge.
   task automatic model_step(input logic rdy, input logic rv, input logic [31:0] rpc);
      int  sz;
      bit  do_pop;
      ent_t e;
      sz     = m_q.size();
      do_pop = (sz != 0) && rdy;
      if (rv) begin
         m_q.delete();
         m_pc   = rpc & 32'hFFFF_FFFC;
         m_halt = 1'b0;
      end else begin
         if (do_pop) void'(m_q.pop_front());
         if (!m_halt && (sz < DEPTH || do_pop)) begin
            e.pc = m_pc;
            e.w  = memword(m_pc, ecall_en, ecall_addr);
            m_q.push_back(e);
            m_pc = m_pc + 32'd4;
`ifdef FETCH_HALT_ON_ECALL_EN
            if (e.w == 32'h0000_0073) m_halt = 1'b1;
`endif
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      logic v;
      v = (m_q.size() != 0);
      chk({tag, ".valid"},  {31'd0, inst_valid}, {31'd0, v});
      chk({tag, ".inst"},   inst,    v ? m_q[0].w  : 32'd0);
      chk({tag, ".pc"},     inst_pc, v ? m_q[0].pc : 32'd0);
      chk({tag, ".addr"},   imem_addr, m_pc);
      chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halt});
   endtask

   task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc, input string tag);
      inst_ready     = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(posedge clk);
      model_step(rdy, rv, rpc);
      #1;
      check_outputs(tag);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check_outputs("reset");
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      model_reset();
      @(negedge clk);
      do_reset();

      // Streaming from reset with the consumer always ready.
      for (int k = 0; k < 6; k++) begin
         cycle(1'b1, 1'b0, 32'd0, "stream");
         chk("stream_pc",   inst_pc, 32'(4 * k));
         chk("stream_inst", inst,    32'h1000_0000 + 32'(k));
      end

      // Backpressure: queue saturates, then drains in order.
      do_reset();
      for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 32'd0, "stall");
      chk("stall_addr", imem_addr, 32'h10);
      chk("stall_head", inst_pc, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         cycle(1'b1, 1'b0, 32'd0, "drain");
         chk("drain_pc", inst_pc, 32'(4 * k));
      end

      // Redirect with three queued entries flushes and realigns.
      do_reset();
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 32'd0, "fill3");
      cycle(1'b0, 1'b1, 32'h0000_0103, "redir");
      chk("redir_valid", {31'd0, inst_valid}, 32'd0);
      chk("redir_addr",  imem_addr, 32'h100);
      cycle(1'b0, 1'b0, 32'd0, "redir_next");
      chk("redir_pc", inst_pc, 32'h100);

      // Address wrap at the top of the space.
      cycle(1'b1, 1'b1, 32'hFFFF_FFFC, "wrap_redir");
      cycle(1'b1, 1'b0, 32'd0, "wrap0");
      chk("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
      cycle(1'b1, 1'b0, 32'd0, "wrap1");
      chk("wrap_pc1", inst_pc, 32'h0000_0000);

      // ECALL at address 8, drain, then redirect to 0x40.
      do_reset();
      ecall_en   = 1'b1;
      ecall_addr = 32'h8;
      for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 32'd0, "ecall_fill");
`ifdef FETCH_HALT_ON_ECALL_EN
      chk("ecall_halted", {31'd0, halted}, 32'd1);
      chk("ecall_addr",   imem_addr, 32'hC);
`endif
      for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 32'd0, "ecall_drain");
      cycle(1'b1, 1'b1, 32'h40, "ecall_redir");
      chk("resume_halted", {31'd0, halted}, 32'd0);
      chk("resume_addr",   imem_addr, 32'h40);
      cycle(1'b0, 1'b0, 32'd0, "resume");
      chk("resume_pc", inst_pc, 32'h40);

      // Asynchronous reset in the middle of a cycle with two entries queued.
      do_reset();
      for (int k = 0; k < 2; k++) cycle(1'b0, 1'b0, 32'd0, "pre_areset");
      #2;
      reset = 1'b1;
      #1;
      chk("areset_valid", {31'd0, inst_valid}, 32'd0);
      chk("areset_addr",  imem_addr, RESET_PC);
      model_reset();
      check_outputs("areset");
      @(negedge clk);
      reset = 1'b0;
      cycle(1'b1, 1'b0, 32'd0, "post_areset");
      chk("post_areset_pc", inst_pc, RESET_PC);

      // Random traffic with occasional redirects, including near the wrap point.
      ecall_addr = 32'h48;
      for (int k = 0; k < 400; k++) begin
         logic        rdy;
         logic        rv;
         logic [31:0] rpc;
         rdy = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 2))
            0:       rpc = $urandom_range(0, 31) << 2 | 32'($urandom_range(0, 3));
            1:       rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: rpc = $urandom;
         endcase
         cycle(rdy, rv, rpc, "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
